// File: rtl/dlx_pkg.sv
// Shared DLX pipeline definitions: default widths, EX/MEM occupancy
// encoding and the packed EX/MEM bundle layout.
package dlx_pkg;

    localparam int DLX_DATA_W = 32;
    localparam int DLX_REG_W  = 5;

    // Occupancy of the EX/MEM skid stage.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,  // no bundle held
        OCC_ONE   = 2'b01,  // main entry full
        OCC_TWO   = 2'b10   // main and skid entries full
    } occ_e;

    // Bundle field order, MSB first: result, carryout, rd, regwrite.
    function automatic int bundle_width(input int data_w, input int reg_w);
        return data_w + 1 + reg_w + 1;
    endfunction

endpackage

// File: rtl/ex_mem_entry.sv
// One EX/MEM bundle register with load enable and asynchronous clear.
module ex_mem_entry #(
    parameter int W = 39
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    // Next value: hold unless loaded.
    always_comb begin
        data_d = load ? d : data_q;
    end

    // Bundle storage register.
    // NOTE: the entry is cleared on reset because it drives out_* directly,
    // and those outputs must read 0 while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/ex_mem_skid.sv
// EX/MEM registered handshake stage: 2-entry skid buffer between the ALU
// and the memory stage, plus a sticky overflow-trap request.
module ex_mem_skid
    import dlx_pkg::*;
#(
    parameter int DATA_W = DLX_DATA_W,
    parameter int REG_W  = DLX_REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_carryout,
    input  logic              in_overflow,
    input  logic              in_trap_en,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_regwrite,
    input  logic [31:0]       in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_carryout,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_regwrite,
    output logic              trap,
    output logic [31:0]       trap_pc,
    input  logic              trap_ack
);

    localparam int BW = bundle_width(DATA_W, REG_W);

    occ_e          state_d, state_q;
    logic          trap_d, trap_q;
    logic [31:0]   trap_pc_d, trap_pc_q;

    logic          accept;
    logic          drain;
    logic          trip;
    logic          main_load;
    logic          skid_load;
    logic [BW-1:0] in_bundle;
    logic [BW-1:0] main_src;
    logic [BW-1:0] main_q;
    logic [BW-1:0] skid_q;

    // Handshake qualifiers; in_ready depends on registers only.
    assign in_ready  = (state_q != OCC_TWO) && !trap_q;
    assign out_valid = (state_q != OCC_EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign trip      = in_overflow && in_trap_en;

    // A trapping op still flows to MEM, but never writes back.
    assign in_bundle = {in_result, in_carryout, in_rd, in_regwrite && !trip};

    // Occupancy next-state and entry load control.
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_src  = in_bundle;
        case (state_q)
            OCC_EMPTY: begin
                if (accept) begin
                    main_load = 1'b1;
                    state_d   = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (accept && drain) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    skid_load = 1'b1;
                    state_d   = OCC_TWO;
                end else if (drain) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                // Skid never bypasses main: it only moves up on a drain.
                if (drain) begin
                    main_load = 1'b1;
                    main_src  = skid_q;
                    state_d   = OCC_ONE;
                end
            end
            default: begin
                state_d = OCC_EMPTY;
            end
        endcase
        // Flush discards the buffer and any bundle offered this cycle.
        if (flush) begin
            state_d   = OCC_EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    // Sticky trap: set by a trapping accept, cleared by trap_ack, kept on flush.
    always_comb begin
        trap_d    = trap_q;
        trap_pc_d = trap_pc_q;
        if (trap_ack) begin
            trap_d = 1'b0;
        end
        if (accept && trip && !flush) begin
            trap_d    = 1'b1;
            trap_pc_d = in_pc;
        end
    end

    // Occupancy and trap registers.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= OCC_EMPTY;
            trap_q    <= 1'b0;
            trap_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            trap_q    <= trap_d;
            trap_pc_q <= trap_pc_d;
        end
    end

    ex_mem_entry #(.W(BW)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load),
        .d     (main_src),
        .q     (main_q)
    );

    ex_mem_entry #(.W(BW)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .d     (in_bundle),
        .q     (skid_q)
    );

    assign {out_result, out_carryout, out_rd, out_regwrite} = main_q;
    assign trap    = trap_q;
    assign trap_pc = trap_pc_q;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Self-checking bench for ex_mem_skid: scoreboard of expected MEM bundles
// plus direct checks of handshake, trap and reset behaviour.
module tb_ex_mem_skid;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_carryout;
    logic        in_overflow;
    logic        in_trap_en;
    logic [4:0]  in_rd;
    logic        in_regwrite;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_carryout;
    logic [4:0]  out_rd;
    logic        out_regwrite;
    logic        trap;
    logic [31:0] trap_pc;
    logic        trap_ack;

    typedef struct packed {
        logic [31:0] result;
        logic        carryout;
        logic [4:0]  rd;
        logic        regwrite;
    } bundle_t;

    bundle_t sb_q[$];
    int      n_checks;
    int      n_pass;

    ex_mem_skid dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_carryout  (in_carryout),
        .in_overflow  (in_overflow),
        .in_trap_en   (in_trap_en),
        .in_rd        (in_rd),
        .in_regwrite  (in_regwrite),
        .in_pc        (in_pc),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carryout (out_carryout),
        .out_rd       (out_rd),
        .out_regwrite (out_regwrite),
        .trap         (trap),
        .trap_pc      (trap_pc),
        .trap_ack     (trap_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        bundle_t exp_b;
        bundle_t got_b;
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    exp_b = sb_q.pop_front();
                    got_b = {out_result, out_carryout, out_rd, out_regwrite};
                    check("out_bundle", 64'(got_b), 64'(exp_b));
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                exp_b.result   = in_result;
                exp_b.carryout = in_carryout;
                exp_b.rd       = in_rd;
                exp_b.regwrite = in_regwrite && !(in_overflow && in_trap_en);
                sb_q.push_back(exp_b);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] result, input logic [4:0] rd, input logic cout,
                         input logic ovf, input logic ten, input logic [31:0] pc,
                         input logic rw);
        in_valid    = 1'b1;
        in_result   = result;
        in_rd       = rd;
        in_carryout = cout;
        in_overflow = ovf;
        in_trap_en  = ten;
        in_pc       = pc;
        in_regwrite = rw;
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_result   = '0;
        in_carryout = 1'b0;
        in_overflow = 1'b0;
        in_trap_en  = 1'b0;
        in_rd       = '0;
        in_regwrite = 1'b0;
        in_pc       = '0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        trap_ack    = 1'b0;

        // Reset state
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_trap", 64'(trap), 64'd0);
        check("rst_trap_pc", 64'(trap_pc), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        step();
        step();
        rst_n = 1'b1;

        // Back-to-back stream with out_ready=1
        offer(32'h0000_00F0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        check("s1_out_valid", 64'(out_valid), 64'd1);
        check("s1_result", 64'(out_result), 64'h0000_00F0);
        check("s1_in_ready", 64'(in_ready), 64'd1);
        offer(32'h0000_000F, 5'd4, 1'b0, 1'b0, 1'b0, 32'h4, 1'b1);
        step();
        in_valid = 1'b0;
        check("s2_out_valid", 64'(out_valid), 64'd1);
        check("s2_result", 64'(out_result), 64'h0000_000F);
        check("s2_in_ready", 64'(in_ready), 64'd1);
        step();
        check("s3_out_valid", 64'(out_valid), 64'd0);

        // Backpressure fills both entries
        out_ready = 1'b0;
        offer(32'h1111_1111, 5'd1, 1'b0, 1'b0, 1'b0, 32'h8, 1'b1);
        step();
        offer(32'h2222_2222, 5'd2, 1'b1, 1'b0, 1'b0, 32'hC, 1'b1);
        step();
        in_valid = 1'b0;
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_head", 64'(out_result), 64'h1111_1111);
        out_ready = 1'b1;
        step();
        check("bp_second", 64'(out_result), 64'h2222_2222);
        check("bp_in_ready_one", 64'(in_ready), 64'd1);
        step();
        check("bp_empty", 64'(out_valid), 64'd0);
        check("bp_in_ready_end", 64'(in_ready), 64'd1);

        // Overflow trap
        offer(32'h7FFF_FFFF, 5'd7, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b1);
        step();
        check("trap_set", 64'(trap), 64'd1);
        check("trap_pc", 64'(trap_pc), 64'h40);
        check("trap_regwrite", 64'(out_regwrite), 64'd0);
        check("trap_carry", 64'(out_carryout), 64'd0);
        check("trap_in_ready", 64'(in_ready), 64'd0);
        offer(32'hDEAD_BEEF, 5'd9, 1'b0, 1'b0, 1'b0, 32'h44, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("trap_hold_ready", 64'(in_ready), 64'd0);
            check("trap_hold", 64'(trap), 64'd1);
        end
        check("trap_drained", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        check("trap_cleared", 64'(trap), 64'd0);
        check("trap_ack_ready", 64'(in_ready), 64'd1);

        // Shift overflow is ignored
        offer(32'h0000_0001, 5'd5, 1'b1, 1'b1, 1'b0, 32'h48, 1'b1);
        step();
        in_valid = 1'b0;
        check("shift_no_trap", 64'(trap), 64'd0);
        check("shift_regwrite", 64'(out_regwrite), 64'd1);
        check("shift_carry", 64'(out_carryout), 64'd1);
        step();

        // Flush in TWO while in_valid=1
        out_ready = 1'b0;
        offer(32'hC0C0_C0C0, 5'd10, 1'b0, 1'b0, 1'b0, 32'h50, 1'b1);
        step();
        offer(32'hD0D0_D0D0, 5'd11, 1'b0, 1'b0, 1'b0, 32'h54, 1'b1);
        step();
        check("fl_two", 64'(in_ready), 64'd0);
        offer(32'hE0E0_E0E0, 5'd12, 1'b0, 1'b0, 1'b0, 32'h58, 1'b1);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_in_ready", 64'(in_ready), 64'd1);

        // Flush in ONE drops the simultaneously accepted bundle
        offer(32'h6060_6060, 5'd13, 1'b0, 1'b0, 1'b0, 32'h5C, 1'b1);
        step();
        offer(32'h7070_7070, 5'd14, 1'b0, 1'b1, 1'b1, 32'h60, 1'b1);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl1_out_valid", 64'(out_valid), 64'd0);
        check("fl1_no_trap", 64'(trap), 64'd0);
        out_ready = 1'b1;
        offer(32'hF0F0_F0F0, 5'd15, 1'b1, 1'b0, 1'b0, 32'h64, 1'b1);
        step();
        in_valid = 1'b0;
        check("fl_after", 64'(out_result), 64'hF0F0_F0F0);
        step();

        // Asynchronous reset in ONE with trap=1
        out_ready = 1'b0;
        offer(32'h8000_0000, 5'd16, 1'b1, 1'b1, 1'b1, 32'h0000_0080, 1'b1);
        step();
        in_valid = 1'b0;
        check("ar_trap_pre", 64'(trap), 64'd1);
        check("ar_valid_pre", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 64'(out_valid), 64'd0);
        check("ar_trap", 64'(trap), 64'd0);
        check("ar_trap_pc", 64'(trap_pc), 64'd0);
        check("ar_in_ready", 64'(in_ready), 64'd1);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Recovery after reset
        offer(32'h1234_5678, 5'd17, 1'b0, 1'b0, 1'b0, 32'h90, 1'b1);
        step();
        in_valid = 1'b0;
        check("rec_result", 64'(out_result), 64'h1234_5678);

        // Bounded wait for the scoreboard to empty
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            step();
        end
        step();
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
